spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_slave_fifo.sv | 54 +++++
 rtl/spi_slave.sv | 226 ++++++++++++++++++++++
 tb/tb_spi_slave.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave.
//   spi_state_e : framing FSM states (IDLE / LOAD / SHIFT)
//   ERR_CNT_W   : width of the optional underrun/overrun event counters
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_e;

  localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/spi_slave_fifo.sv
// Synchronous show-ahead FIFO (module fifo), used for both SPI TX and RX.
// Ports:
//   clk_i, rst_ni          : clock, async active-low reset
//   wr_en_i, wr_data_i     : push side; a push while full is ignored
//   full_o                 : no free entry
//   rd_en_i                : pop; a pop while empty is ignored
//   rd_data_o              : head entry, valid combinationally while !empty_o
//   empty_o                : no stored entry
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             full_o,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_wr, do_rd;

  assign full_o    = (cnt_q == CW'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign do_wr     = wr_en_i & ~full_o;
  assign do_rd     = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_wr) wptr_q <= (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1);
      if (do_rd) rptr_q <= (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + AW'(1);
      if (do_wr && !do_rd)      cnt_q <= cnt_q + CW'(1);
      else if (!do_wr && do_rd) cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/spi_slave.sv
// SPI slave with TX/RX FIFOs, all SPI modes, MSB- or LSB-first.
// Ports:
//   clk, rst_n                      : system clock, async active-low reset
//   cpol, cpha, lsb_first           : mode / bit order, static while cs low
//   sclk, cs, mosi                  : async SPI pins (cs active-low)
//   miso, miso_oe                   : serial out and pad enable
//   tx_wr_en, tx_wr_data, tx_full   : TX FIFO write side
//   rx_rd_en, rx_rd_data, rx_empty  : RX FIFO read side (data on clk after rd)
//   done, underrun, overrun         : single-clk status pulses
// Optional (macro SPI_SLAVE_ERR_CNT_EN):
//   err_cnt_clr                     : clears both counters
//   underrun_cnt, overrun_cnt       : saturating pulse counters
//
// state    | meaning
// IDLE     | cs high or no frame started; miso tri-stated
// LOAD     | one clk: fetch next TX word (or zeros) into the shifter
// SHIFT    | shifting DATA_WIDTH bits in and out
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic                  tx_wr_en,
  input  logic [DATA_WIDTH-1:0] tx_wr_data,
  output logic                  tx_full,
  input  logic                  rx_rd_en,
  output logic [DATA_WIDTH-1:0] rx_rd_data,
  output logic                  rx_empty,
  output logic                  done,
  output logic                  underrun,
  output logic                  overrun
`ifdef SPI_SLAVE_ERR_CNT_EN
  ,
  input  logic                  err_cnt_clr,
  output logic [ERR_CNT_W-1:0]  underrun_cnt,
  output logic [ERR_CNT_W-1:0]  overrun_cnt
`endif
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic       sclk_prev_q, cs_prev_q;
  logic       sclk_s, cs_s, mosi_s;
  logic       lead_edge, trail_edge, sample_edge, shift_edge, cs_fall;

  spi_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  miso_q, miso_d;
  logic                  done_q, done_d, under_q, under_d, over_q, over_d;
  logic [DATA_WIDTH-1:0] rx_rd_data_q;

  logic                  tx_empty, tx_pop, rx_full, rx_push;
  logic [DATA_WIDTH-1:0] tx_head, rx_head, load_word, out_src, out_rest, rx_next;
  logic                  out_bit;

  assign sclk_s = sclk_sync_q[1];
  assign cs_s   = cs_sync_q[1];
  assign mosi_s = mosi_sync_q[1];

  assign lead_edge   = (sclk_prev_q == cpol) && (sclk_s != cpol);
  assign trail_edge  = (sclk_prev_q != cpol) && (sclk_s == cpol);
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;
  assign cs_fall     = cs_prev_q & ~cs_s;

  // In LOAD the outgoing bit comes from the freshly fetched word, otherwise
  // from the shifter.
  assign load_word = tx_empty ? '0 : tx_head;
  assign out_src   = (state_q == ST_LOAD) ? load_word : tx_sr_q;
  assign out_bit   = lsb_first ? out_src[0] : out_src[DATA_WIDTH-1];
  assign out_rest  = lsb_first ? (out_src >> 1) : (out_src << 1);
  assign rx_next   = lsb_first ? {mosi_s, rx_sr_q[DATA_WIDTH-1:1]}
                               : {rx_sr_q[DATA_WIDTH-2:0], mosi_s};

  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    bit_cnt_d = bit_cnt_q;
    miso_d    = miso_q;
    done_d    = 1'b0;
    under_d   = 1'b0;
    over_d    = 1'b0;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    if (cs_s) begin
      // cs high overrides everything: a partial word is simply dropped.
      state_d = ST_IDLE;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (cs_fall) state_d = ST_LOAD;
        ST_LOAD: begin
          tx_pop    = ~tx_empty;
          under_d   = tx_empty;
          bit_cnt_d = CW'(DATA_WIDTH);
          rx_sr_d   = '0;
          if (!cpha) begin
            miso_d  = out_bit;
            tx_sr_d = out_rest;
          end else begin
            tx_sr_d = load_word;
          end
          state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          // With cpha=0 the first bit is already out, and the trailing edge
          // that closes the previous word lands here before any sample.
          if (shift_edge && (cpha || bit_cnt_q != CW'(DATA_WIDTH))) begin
            miso_d  = out_bit;
            tx_sr_d = out_rest;
          end
          if (sample_edge) begin
            rx_sr_d   = rx_next;
            bit_cnt_d = bit_cnt_q - CW'(1);
            if (bit_cnt_q == CW'(1)) begin
              rx_push = 1'b1;
              over_d  = rx_full;
              done_d  = 1'b1;
              state_d = ST_LOAD;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q  <= '0;
      cs_sync_q    <= '0;
      mosi_sync_q  <= '0;
      sclk_prev_q  <= 1'b0;
      cs_prev_q    <= 1'b0;
      state_q      <= ST_IDLE;
      tx_sr_q      <= '0;
      rx_sr_q      <= '0;
      bit_cnt_q    <= '0;
      miso_q       <= 1'b0;
      done_q       <= 1'b0;
      under_q      <= 1'b0;
      over_q       <= 1'b0;
      rx_rd_data_q <= '0;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[0], sclk};
      cs_sync_q    <= {cs_sync_q[0], cs};
      mosi_sync_q  <= {mosi_sync_q[0], mosi};
      sclk_prev_q  <= sclk_s;
      cs_prev_q    <= cs_s;
      state_q      <= state_d;
      tx_sr_q      <= tx_sr_d;
      rx_sr_q      <= rx_sr_d;
      bit_cnt_q    <= bit_cnt_d;
      miso_q       <= miso_d;
      done_q       <= done_d;
      under_q      <= under_d;
      over_q       <= over_d;
      if (rx_rd_en && !rx_empty) rx_rd_data_q <= rx_head;
    end
  end

  assign miso_oe    = (state_q != ST_IDLE) & ~cs_s;
  assign miso       = miso_oe & miso_q;
  assign done       = done_q;
  assign underrun   = under_q;
  assign overrun    = over_q;
  assign rx_rd_data = rx_rd_data_q;

  fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en_i   (tx_wr_en),
    .wr_data_i (tx_wr_data),
    .full_o    (tx_full),
    .rd_en_i   (tx_pop),
    .rd_data_o (tx_head),
    .empty_o   (tx_empty)
  );

  fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en_i   (rx_push),
    .wr_data_i (rx_next),
    .full_o    (rx_full),
    .rd_en_i   (rx_rd_en),
    .rd_data_o (rx_head),
    .empty_o   (rx_empty)
  );

`ifdef SPI_SLAVE_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] ucnt_q, ocnt_q;

  // Clear wins over a coincident pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ucnt_q <= '0;
      ocnt_q <= '0;
    end else if (err_cnt_clr) begin
      ucnt_q <= '0;
      ocnt_q <= '0;
    end else begin
      if (under_q && ucnt_q != '1) ucnt_q <= ucnt_q + ERR_CNT_W'(1);
      if (over_q && ocnt_q != '1)  ocnt_q <= ocnt_q + ERR_CNT_W'(1);
    end
  end

  assign underrun_cnt = ucnt_q;
  assign overrun_cnt  = ocnt_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int H = 6;   // sclk half period in clk cycles

  logic clk = 1'b0, rst_n = 1'b0;
  logic cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
  logic tx_wr_en = 1'b0, rx_rd_en = 1'b0;
  logic [DW-1:0] tx_wr_data = '0;
  logic miso, miso_oe, tx_full, rx_empty, done, underrun, overrun;
  logic [DW-1:0] rx_rd_data;
`ifdef SPI_SLAVE_ERR_CNT_EN
  logic err_cnt_clr = 1'b0;
  logic [7:0] underrun_cnt, overrun_cnt;
`endif

  always #5 clk = ~clk;

  spi_slave #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .tx_full(tx_full),
    .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data), .rx_empty(rx_empty),
    .done(done), .underrun(underrun), .overrun(overrun)
`ifdef SPI_SLAVE_ERR_CNT_EN
    , .err_cnt_clr(err_cnt_clr), .underrun_cnt(underrun_cnt), .overrun_cnt(overrun_cnt)
`endif
  );

  int errors = 0, checks = 0;
  int done_seen = 0, under_seen = 0, over_seen = 0;
  int exp_done = 0, exp_under = 0, exp_over = 0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] mosi_arr [32];
  logic [7:0] last_rd = '0;

  always @(negedge clk) begin
    if (done)     done_seen++;
    if (underrun) under_seen++;
    if (overrun)  over_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(input logic c, input logic p, input logic l);
    cpol = c; cpha = p; lsb_first = l; sclk = c;
    wait_clk(4);
  endtask

  task automatic push_tx(input logic [7:0] d);
    tx_wr_data = d; tx_wr_en = 1'b1;
    wait_clk(1);
    tx_wr_en = 1'b0;
    if (txq.size() < DEPTH) txq.push_back(d);
    chk("tx_full", tx_full, txq.size() == DEPTH);
  endtask

  task automatic read_rx();
    chk("rx_empty", rx_empty, rxq.size() == 0);
    rx_rd_en = 1'b1;
    wait_clk(1);
    rx_rd_en = 1'b0;
    if (rxq.size() > 0) last_rd = rxq.pop_front();
    chk("rx_data", rx_rd_data, last_rd);
  endtask

  // Master side of one word. When 'last' is set cs is released one clk after
  // the final sample edge, before the slave can start fetching another word.
  task automatic xfer(input logic [7:0] mw, input int nbits, input bit last,
                      output logic [7:0] got);
    int idx;
    bit fin;
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = lsb_first ? i : 7 - i;
      fin = last && (i == nbits - 1);
      if (!cpha) begin
        mosi = mw[idx];
        wait_clk(H);
        got[idx] = miso;
        sclk = ~cpol;
        if (fin) begin wait_clk(1); cs = 1'b1; end
        wait_clk(H);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = mw[idx];
        wait_clk(H);
        got[idx] = miso;
        sclk = cpol;
        if (fin) begin wait_clk(1); cs = 1'b1; end
        wait_clk(H);
      end
    end
  endtask

  // Frame of n words from mosi_arr; model: each word start takes the TX head
  // or zeros (underrun); each completed word goes to RX unless it is full.
  task automatic frame(input int n);
    logic [7:0] got, e;
    cs = 1'b0;
    wait_clk(H);
    for (int w = 0; w < n; w++) begin
      if (txq.size() > 0) e = txq.pop_front();
      else begin e = '0; exp_under++; end
      xfer(mosi_arr[w], DW, w == n - 1, got);
      chk("miso_word", got, e);
      if (rxq.size() < DEPTH) rxq.push_back(mosi_arr[w]);
      else exp_over++;
      exp_done++;
    end
    wait_clk(8);
    chk("miso_oe_after", miso_oe, 0);
    chk("done_cnt", done_seen, exp_done);
    chk("underrun_cnt", under_seen, exp_under);
    chk("overrun_cnt", over_seen, exp_over);
  endtask

  initial begin
    logic [7:0] got;
    int n, k, lat;

    wait_clk(3);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_miso", miso, 0);
    chk("rst_miso_oe", miso_oe, 0);
    chk("rst_pulses", {done, underrun, overrun}, 0);
    chk("rst_rx_data", rx_rd_data, 0);
    rst_n = 1'b1;
    wait_clk(4);

    // Mode 0, MSB first
    set_mode(0, 0, 0);
    push_tx(8'hA5);
    mosi_arr[0] = 8'h3C;
    frame(1);
    read_rx();

    // Modes 1..3, LSB first
    for (int m = 1; m < 4; m++) begin
      set_mode(m[1], m[0], 1'b1);
      push_tx(8'h81);
      mosi_arr[0] = 8'h0F;
      frame(1);
      read_rx();
    end

    // Three words, two queued: third goes out as zeros with one underrun
    set_mode(0, 0, 0);
    push_tx(8'h11);
    push_tx(8'h22);
    for (int i = 0; i < 3; i++) mosi_arr[i] = 8'($urandom);
    frame(3);
    while (rxq.size() > 0) read_rx();

    // Randomized modes, preloads and frame lengths
    repeat (12) begin
      set_mode(1'($urandom), 1'($urandom), 1'($urandom));
      k = $urandom_range(0, 3);
      for (int i = 0; i < k; i++) push_tx(8'($urandom));
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) mosi_arr[i] = 8'($urandom);
      frame(n);
      while (rxq.size() > 0) read_rx();
    end

    // TX full boundary, then RX overrun on the 17th word
    set_mode(1, 1, 0);
    for (int i = 0; i < DEPTH + 1; i++) push_tx(8'($urandom));
    for (int i = 0; i < DEPTH; i++) mosi_arr[i] = 8'($urandom);
    frame(DEPTH);
    mosi_arr[0] = 8'($urandom);
    frame(1);
`ifdef SPI_SLAVE_ERR_CNT_EN
    chk("overrun_cnt_reg", overrun_cnt, exp_over);
    chk("underrun_cnt_reg", underrun_cnt, exp_under);
    err_cnt_clr = 1'b1;
    wait_clk(1);
    err_cnt_clr = 1'b0;
    chk("cnt_cleared", {underrun_cnt, overrun_cnt}, 0);
`endif
    while (rxq.size() > 0) read_rx();
    chk("rx_empty_drained", rx_empty, 1);
    // read while empty is ignored
    rx_rd_en = 1'b1;
    wait_clk(1);
    rx_rd_en = 1'b0;
    chk("rd_empty_hold", rx_rd_data, last_rd);

    // Abort after 5 bits
    set_mode(0, 0, 0);
    cs = 1'b0;
    wait_clk(H);
    exp_under++;
    xfer(8'($urandom), 5, 1'b0, got);
    cs = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      wait_clk(1);
      if (!miso_oe) begin lat = i; break; end
    end
    chk("abort_oe_within3", (lat >= 1) && (lat <= 3), 1);
    wait_clk(8);
    chk("abort_done", done_seen, exp_done);
    chk("abort_underrun", under_seen, exp_under);
    chk("abort_rx_empty", rx_empty, 1);
    push_tx(8'h5A);
    mosi_arr[0] = 8'hC3;
    frame(1);
    read_rx();

    // Reset mid-word with both FIFOs holding data
    set_mode(0, 1, 0);
    mosi_arr[0] = 8'h96;
    frame(1);
    for (int i = 0; i < DEPTH; i++) push_tx(8'($urandom));
    cs = 1'b0;
    wait_clk(H);
    void'(txq.pop_front());
    push_tx(8'h77);
    xfer(8'($urandom), 3, 1'b0, got);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_full", tx_full, 0);
    chk("mid_rst_rx_empty", rx_empty, 1);
    chk("mid_rst_miso", {miso, miso_oe}, 0);
    chk("mid_rst_pulses", {done, underrun, overrun}, 0);
    chk("mid_rst_rx_data", rx_rd_data, 0);
    txq.delete();
    rxq.delete();
    last_rd = '0;
    cs = 1'b1;
    sclk = cpol;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    chk("post_rst_rx_empty", rx_empty, 1);
    chk("post_rst_done", done_seen, exp_done);
`ifdef SPI_SLAVE_ERR_CNT_EN
    chk("post_rst_cnts", {underrun_cnt, overrun_cnt}, 0);
`endif
    push_tx(8'hE1);
    mosi_arr[0] = 8'h2B;
    frame(1);
    read_rx();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
